membus_arb: RTL and testbench

//  Two-port arbiter and cycle sequencer in front of one core memory module (mem0-style core).

---
 rtl/membus_arb.sv | 204 ++++++++++++++++++++
 tb/tb_membus_arb.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/membus_arb.sv
// membus_arb: two-port arbiter and cycle sequencer in front of one core memory module.
// One read, write or read-pause-write cycle runs at a time; an unanswered cycle reports NXM.
module membus_arb #(
    parameter int NXM_TIMEOUT = 100,
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_rq_cyc,
    input  logic        p0_rd_rq,
    input  logic        p0_wr_rq,
    input  logic [17:0] p0_ma,
    input  logic [35:0] p0_wr_data,
    input  logic        p0_wr_rs,
    output logic        p0_addr_ack,
    output logic        p0_rd_rs,
    output logic [35:0] p0_rd_data,
    output logic        p0_nxm,
    input  logic        p1_rq_cyc,
    input  logic        p1_rd_rq,
    input  logic        p1_wr_rq,
    input  logic [17:0] p1_ma,
    input  logic [35:0] p1_wr_data,
    input  logic        p1_wr_rs,
    output logic        p1_addr_ack,
    output logic        p1_rd_rs,
    output logic [35:0] p1_rd_data,
    output logic        p1_nxm,
    output logic        mem_rq_cyc,
    output logic        mem_rd_rq,
    output logic        mem_wr_rq,
    output logic [17:0] mem_ma,
    output logic        mem_sel,
    output logic [35:0] mem_wr_data,
    output logic        mem_wr_rs,
    input  logic        mem_addr_ack,
    input  logic        mem_rd_rs,
    input  logic [35:0] mem_rd_data,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_RDWAIT = 3'd2,
        S_WRWAIT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [9:0] TMO_LAST = 10'(NXM_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sel;
    logic        r_last;
    logic        r_rd;
    logic        r_wr;
    logic [17:0] r_ma;
    logic [9:0]  r_cnt;
    logic [1:0]  r_ack;
    logic [1:0]  r_rd_rs;
    logic [1:0]  r_nxm;
    logic [35:0] r_rd_data0;
    logic [35:0] r_rd_data1;
    logic [35:0] r_mem_wr_data;
    logic        r_mem_wr_rs;

    logic        w_req0;
    logic        w_req1;
    logic        w_win;
    logic        w_own_rq_cyc;
    logic        w_own_wr_rs;
    logic [35:0] w_own_wr_data;
    logic        w_busy;
    logic        w_grant;
    logic        w_ack_ev;
    logic        w_nxm_ev;
    logic        w_rd_ev;
    logic        w_wr_ev;
    logic        w_release;

    assign w_req0 = p0_rq_cyc & (p0_rd_rq | p0_wr_rq);
    assign w_req1 = p1_rq_cyc & (p1_rd_rq | p1_wr_rq);
    // On a tie, fixed priority picks port 0; round robin picks the port that did not win last.
    assign w_win  = (w_req0 && w_req1) ? (ROUND_ROBIN ? ~r_last : 1'b0) : w_req1;

    assign w_own_rq_cyc  = r_sel ? p1_rq_cyc  : p0_rq_cyc;
    assign w_own_wr_rs   = r_sel ? p1_wr_rs   : p0_wr_rs;
    assign w_own_wr_data = r_sel ? p1_wr_data : p0_wr_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_ack_ev    = 1'b0;
        w_nxm_ev    = 1'b0;
        w_rd_ev     = 1'b0;
        w_wr_ev     = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req0 || w_req1) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                // An ack on the expiry tick still wins over the timeout.
                if (mem_addr_ack) begin
                    w_ack_ev    = 1'b1;
                    w_state_nxt = r_rd ? S_RDWAIT : S_WRWAIT;
                end else if (r_cnt == TMO_LAST) begin
                    w_nxm_ev    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_RDWAIT: begin
                if (mem_rd_rs) begin
                    w_rd_ev     = 1'b1;
                    w_state_nxt = r_wr ? S_WRWAIT : S_DONE;
                end
            end
            S_WRWAIT: begin
                if (w_own_wr_rs) begin
                    w_wr_ev     = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!w_own_rq_cyc) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel         <= 1'b0;
            r_last        <= 1'b1;
            r_rd          <= 1'b0;
            r_wr          <= 1'b0;
            r_ma          <= '0;
            r_cnt         <= '0;
            r_ack         <= '0;
            r_rd_rs       <= '0;
            r_nxm         <= '0;
            r_rd_data0    <= '0;
            r_rd_data1    <= '0;
            r_mem_wr_data <= '0;
            r_mem_wr_rs   <= 1'b0;
        end else begin
            r_ack       <= '0;
            r_rd_rs     <= '0;
            r_nxm       <= '0;
            r_mem_wr_rs <= 1'b0;
            if (w_grant) begin
                r_sel <= w_win;
                r_ma  <= w_win ? p1_ma    : p0_ma;
                r_rd  <= w_win ? p1_rd_rq : p0_rd_rq;
                r_wr  <= w_win ? p1_wr_rq : p0_wr_rq;
            end
            if (r_state == S_ADDR && !w_ack_ev && !w_nxm_ev) r_cnt <= r_cnt + 10'd1;
            else                                             r_cnt <= '0;
            if (w_ack_ev) r_ack[r_sel] <= 1'b1;
            if (w_nxm_ev) r_nxm[r_sel] <= 1'b1;
            if (w_rd_ev) begin
                r_rd_rs[r_sel] <= 1'b1;
                if (r_sel) r_rd_data1 <= mem_rd_data;
                else       r_rd_data0 <= mem_rd_data;
            end
            if (w_wr_ev) begin
                r_mem_wr_data <= w_own_wr_data;
                r_mem_wr_rs   <= 1'b1;
            end
            if (w_release) r_last <= r_sel;
        end
    end

    assign w_busy      = (r_state == S_ADDR) || (r_state == S_RDWAIT) || (r_state == S_WRWAIT);
    assign mem_rq_cyc  = w_busy;
    assign mem_rd_rq   = w_busy & r_rd;
    assign mem_wr_rq   = w_busy & r_wr;
    assign mem_ma      = r_ma;
    assign mem_sel     = r_sel;
    assign mem_wr_data = r_mem_wr_data;
    assign mem_wr_rs   = r_mem_wr_rs;
    assign p0_addr_ack = r_ack[0];
    assign p1_addr_ack = r_ack[1];
    assign p0_rd_rs    = r_rd_rs[0];
    assign p1_rd_rs    = r_rd_rs[1];
    assign p0_nxm      = r_nxm[0];
    assign p1_nxm      = r_nxm[1];
    assign p0_rd_data  = r_rd_data0;
    assign p1_rd_data  = r_rd_data1;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_membus_arb.sv
// Bench for membus_arb: a fixed-priority and a round-robin instance, each driven by bench
// requesters and a bench memory, compared against a transaction-level model.
`timescale 1ns/1ps
module tb_membus_arb;
    localparam int NXM = 100;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        rq_cyc [2][2];
    logic        rd_rq  [2][2];
    logic        wr_rq  [2][2];
    logic [17:0] ma     [2][2];
    logic [35:0] wdat   [2][2];
    logic        wr_rs  [2][2];
    logic        m_ack     [2];
    logic        m_rd_rs   [2];
    logic [35:0] m_rd_data [2];

    logic        addr_ack [2][2];
    logic        rd_rs    [2][2];
    logic [35:0] rd_dat   [2][2];
    logic        nxm      [2][2];
    logic        m_rq_cyc [2];
    logic        m_rd_rq  [2];
    logic        m_wr_rq  [2];
    logic [17:0] m_ma     [2];
    logic        m_sel    [2];
    logic [35:0] m_wdat   [2];
    logic        m_wr_rs  [2];
    logic [2:0]  dbg      [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        membus_arb #(.NXM_TIMEOUT(NXM), .ROUND_ROBIN(g == 1)) u_dut (
            .clk(clk), .reset(reset),
            .p0_rq_cyc(rq_cyc[g][0]), .p0_rd_rq(rd_rq[g][0]), .p0_wr_rq(wr_rq[g][0]),
            .p0_ma(ma[g][0]), .p0_wr_data(wdat[g][0]), .p0_wr_rs(wr_rs[g][0]),
            .p0_addr_ack(addr_ack[g][0]), .p0_rd_rs(rd_rs[g][0]), .p0_rd_data(rd_dat[g][0]),
            .p0_nxm(nxm[g][0]),
            .p1_rq_cyc(rq_cyc[g][1]), .p1_rd_rq(rd_rq[g][1]), .p1_wr_rq(wr_rq[g][1]),
            .p1_ma(ma[g][1]), .p1_wr_data(wdat[g][1]), .p1_wr_rs(wr_rs[g][1]),
            .p1_addr_ack(addr_ack[g][1]), .p1_rd_rs(rd_rs[g][1]), .p1_rd_data(rd_dat[g][1]),
            .p1_nxm(nxm[g][1]),
            .mem_rq_cyc(m_rq_cyc[g]), .mem_rd_rq(m_rd_rq[g]), .mem_wr_rq(m_wr_rq[g]),
            .mem_ma(m_ma[g]), .mem_sel(m_sel[g]), .mem_wr_data(m_wdat[g]), .mem_wr_rs(m_wr_rs[g]),
            .mem_addr_ack(m_ack[g]), .mem_rd_rs(m_rd_rs[g]), .mem_rd_data(m_rd_data[g]),
            .o_dbg_state(dbg[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: counts and timestamps (in posedges) of one-clk output pulses.
    int   cyc = 0;
    int   n_ack [2][2], t_ack [2][2], n_rdrs [2][2], t_rdrs [2][2], n_nxm [2][2], t_nxm [2][2];
    int   n_mwrs [2], t_mwrs [2], n_rqc [2];
    logic prev_rqc [2];

    always @(posedge clk) begin
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                if (addr_ack[d][p]) begin n_ack[d][p]++;  t_ack[d][p] = cyc;  end
                if (rd_rs[d][p])    begin n_rdrs[d][p]++; t_rdrs[d][p] = cyc; end
                if (nxm[d][p])      begin n_nxm[d][p]++;  t_nxm[d][p] = cyc;  end
            end
            if (m_wr_rs[d]) begin n_mwrs[d]++; t_mwrs[d] = cyc; end
            if (m_rq_cyc[d] && !prev_rqc[d]) n_rqc[d]++;
            prev_rqc[d] = m_rq_cyc[d];
        end
    end

    // Reference model: bench memory contents, last winner and each port's held read data.
    logic [35:0] mem_model [int];
    int          model_last [2];
    logic [35:0] exp_rd [2][2];

    function automatic logic [35:0] mem_val(input int d, input logic [17:0] a);
        int key = d * 262144 + int'(a);
        if (mem_model.exists(key)) return mem_model[key];
        return {a, 18'o525252};
    endfunction

    function automatic int winner(input int d);
        return (d == 1) ? 1 - model_last[d] : 0;
    endfunction

    function automatic logic [35:0] rand36();
        return {4'($urandom_range(15)), 32'($urandom())};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_mon(input int d);
        for (int p = 0; p < 2; p++) begin
            n_ack[d][p] = 0; n_rdrs[d][p] = 0; n_nxm[d][p] = 0;
        end
        n_mwrs[d] = 0;
        n_rqc[d]  = 0;
    endtask

    task automatic drive_req(input int d, input int p, input logic rd, input logic wr,
                             input logic [17:0] a, input logic [35:0] wd, input logic early);
        rq_cyc[d][p] = 1'b1;
        rd_rq[d][p]  = rd;
        wr_rq[d][p]  = wr;
        ma[d][p]     = a;
        wdat[d][p]   = wd;
        wr_rs[d][p]  = early & wr;
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk({tag, " ctl"}, {m_rq_cyc[d], m_rd_rq[d], m_wr_rq[d], m_sel[d], m_wr_rs[d],
            addr_ack[d][0], addr_ack[d][1], rd_rs[d][0], rd_rs[d][1], nxm[d][0], nxm[d][1]}, 0);
        chk({tag, " mem_ma"}, m_ma[d], 0);
        chk({tag, " mem_wr_data"}, m_wdat[d], 0);
        chk({tag, " rd_data0"}, rd_dat[d][0], 0);
        chk({tag, " rd_data1"}, rd_dat[d][1], 0);
    endtask

    // Runs one granted cycle for port p whose request is already driven, acting as the memory.
    task automatic serve(input int d, input int p, input int ack_dly, input int rs_dly,
                         input int wrs_dly, input int hold, input logic exp_nxm);
        string       s;
        int          ta, tc, tw, k, q;
        logic        lrd, lwr;
        logic [17:0] a;
        logic [35:0] wd, rdv;
        s   = $sformatf("d%0d p%0d", d, p);
        q   = 1 - p;
        lrd = rd_rq[d][p];
        lwr = wr_rq[d][p];
        a   = ma[d][p];
        wd  = wdat[d][p];
        clear_mon(d);
        tc = cyc;
        k  = 0;
        while (!m_rq_cyc[d] && k < 8) begin step(); k++; end
        chk({s, " grant_lat"}, cyc - tc, 1);
        chk({s, " mem_sel"}, m_sel[d], p);
        chk({s, " mem_ma"}, m_ma[d], a);
        chk({s, " mem_rd_wr_rq"}, {m_rd_rq[d], m_wr_rq[d]}, {lrd, lwr});
        ta = cyc;
        if (exp_nxm) begin
            k = 0;
            while (n_nxm[d][p] == 0 && k < NXM + 8) begin step(); k++; end
            chk({s, " nxm_time"}, t_nxm[d][p] - ta, NXM);
        end else begin
            repeat (ack_dly) step();
            m_ack[d] = 1'b1;
            tc = cyc;
            step();
            m_ack[d] = 1'b0;
            chk({s, " ack_pulse"}, addr_ack[d][p], 1);
            chk({s, " ack_time"}, t_ack[d][p] - tc, 1);
            tw = t_ack[d][p];
            if (lrd) begin
                repeat (rs_dly) step();
                rdv = mem_val(d, a);
                m_rd_rs[d]   = 1'b1;
                m_rd_data[d] = rdv;
                tc = cyc;
                step();
                m_rd_rs[d]   = 1'b0;
                m_rd_data[d] = rand36();
                chk({s, " rd_rs_time"}, t_rdrs[d][p] - tc, 1);
                chk({s, " rd_data"}, rd_dat[d][p], rdv);
                exp_rd[d][p] = rdv;
                tw = t_rdrs[d][p];
            end
            if (lwr) begin
                if (!wr_rs[d][p]) begin
                    repeat (wrs_dly) step();
                    wr_rs[d][p] = 1'b1;
                    tw = cyc;
                end
                k = 0;
                while (n_mwrs[d] == 0 && k < 8) begin step(); k++; end
                wr_rs[d][p] = 1'b0;
                chk({s, " wr_rs_time"}, t_mwrs[d] - tw, 1);
                chk({s, " mem_wr_data"}, m_wdat[d], wd);
                mem_model[d * 262144 + int'(a)] = wd;
            end
        end
        chk({s, " done_rq_cyc"}, m_rq_cyc[d], 0);
        repeat (hold) step();
        chk({s, " hold_rq_cyc"}, m_rq_cyc[d], 0);
        chk({s, " rq_cyc_assertions"}, n_rqc[d], 1);
        chk({s, " pulse_counts"}, {8'(n_ack[d][p]), 8'(n_rdrs[d][p]), 8'(n_mwrs[d]), 8'(n_nxm[d][p])},
            {8'(!exp_nxm), 8'(lrd && !exp_nxm), 8'(lwr && !exp_nxm), 8'(exp_nxm)});
        chk({s, " other_port_quiet"}, n_ack[d][q] + n_rdrs[d][q] + n_nxm[d][q], 0);
        chk({s, " rd_data_held"}, {rd_dat[d][0], rd_dat[d][1]}, {exp_rd[d][0], exp_rd[d][1]});
        rq_cyc[d][p] = 1'b0;
        rd_rq[d][p]  = 1'b0;
        wr_rq[d][p]  = 1'b0;
        wr_rs[d][p]  = 1'b0;
        model_last[d] = p;
        step();
    endtask

    task automatic contend(input int d);
        int w;
        drive_req(d, 0, 1'b1, 1'b0, 18'($urandom_range(7)), 36'd0, 1'b0);
        drive_req(d, 1, 1'b1, 1'b0, 18'($urandom_range(7)), 36'd0, 1'b0);
        for (int g = 0; g < 3; g++) begin
            w = winner(d);
            serve(d, w, $urandom_range(2), $urandom_range(2), 0, $urandom_range(1), 1'b0);
            if (g < 2) drive_req(d, w, 1'b1, 1'b0, 18'($urandom_range(7)), 36'd0, 1'b0);
        end
        serve(d, 1 - w, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic reset_mid(input int d);
        int k;
        drive_req(d, 0, 1'b1, 1'b0, 18'o3, 36'd0, 1'b0);
        k = 0;
        while (!m_rq_cyc[d] && k < 8) begin step(); k++; end
        m_ack[d] = 1'b1;
        step();
        m_ack[d] = 1'b0;
        drive_req(d, 1, 1'b1, 1'b0, 18'o4, 36'd0, 1'b0);
        step();
        reset = 1'b0;
        step();
        step();
        chk_zero(d, $sformatf("d%0d reset_mid", d));
        rq_cyc[d][0] = 1'b0;
        rd_rq[d][0]  = 1'b0;
        for (int e = 0; e < 2; e++) begin
            model_last[e] = 1;
            exp_rd[e][0]  = '0;
            exp_rd[e][1]  = '0;
        end
        reset = 1'b1;
        serve(d, 1, 1, 1, 0, 1, 1'b0);
    endtask

    task automatic run_dut(input int d);
        int          p, ty, w;
        logic        lrd, lwr;
        mem_model[d * 262144 + 18'o1000] = 36'o111777222666;
        drive_req(d, 0, 1'b1, 1'b0, 18'o1000, 36'd0, 1'b0);
        serve(d, 0, 3, 0, 0, 1, 1'b0);
        drive_req(d, 1, 1'b0, 1'b1, 18'o2, 36'o123456654321, 1'b0);
        serve(d, 1, 0, 0, 1, 3, 1'b0);
        drive_req(d, 0, 1'b1, 1'b0, 18'o2, 36'd0, 1'b0);
        serve(d, 0, 0, 0, 0, 0, 1'b0);
        drive_req(d, 0, 1'b1, 1'b1, 18'o17, 36'o777777777777, 1'b1);
        serve(d, 0, 1, 2, 0, 0, 1'b0);
        drive_req(d, 1, 1'b1, 1'b0, 18'o17, 36'd0, 1'b0);
        serve(d, 1, 0, 0, 0, 0, 1'b0);
        drive_req(d, 0, 1'b1, 1'b0, 18'o777000, 36'd0, 1'b0);
        serve(d, 0, 0, 0, 0, 1, 1'b1);
        drive_req(d, 0, 1'b1, 1'b0, 18'o777001, 36'd0, 1'b0);
        serve(d, 0, NXM - 1, 0, 0, 0, 1'b0);
        contend(d);
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(3) == 0) begin
                for (int pp = 0; pp < 2; pp++) begin
                    ty  = $urandom_range(2);
                    lrd = (ty != 1);
                    lwr = (ty != 0);
                    drive_req(d, pp, lrd, lwr, 18'($urandom_range(7)), rand36(), lwr && ($urandom_range(1) == 1));
                end
                w = winner(d);
                serve(d, w, $urandom_range(4), $urandom_range(3), $urandom_range(2), $urandom_range(2), 1'b0);
                serve(d, 1 - w, $urandom_range(4), $urandom_range(3), $urandom_range(2), 0, 1'b0);
            end else begin
                p   = $urandom_range(1);
                ty  = $urandom_range(2);
                lrd = (ty != 1);
                lwr = (ty != 0);
                drive_req(d, p, lrd, lwr, 18'($urandom_range(7)), rand36(), lwr && ($urandom_range(1) == 1));
                serve(d, p, $urandom_range(4), $urandom_range(3), $urandom_range(2), $urandom_range(2), 1'b0);
            end
        end
        reset_mid(d);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                rq_cyc[d][p] = 1'b0; rd_rq[d][p] = 1'b0; wr_rq[d][p] = 1'b0;
                ma[d][p] = '0; wdat[d][p] = '0; wr_rs[d][p] = 1'b0;
                exp_rd[d][p] = '0;
            end
            m_ack[d] = 1'b0; m_rd_rs[d] = 1'b0; m_rd_data[d] = '0;
            prev_rqc[d] = 1'b0;
            model_last[d] = 1;
            clear_mon(d);
        end
        repeat (3) step();
        for (int d = 0; d < 2; d++) chk_zero(d, $sformatf("d%0d reset", d));
        reset = 1'b1;
        step();
        for (int d = 0; d < 2; d++) run_dut(d);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
